// File: rtl/axi_arbiter_pkg.sv
// Shared types and constants for the four-input AXI-Stream packet arbiter.
package axi_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int N_CH       = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/axi_arbiter_if.sv
// AXI-Stream bundle used on every arbiter input and on the merged output.
// Handshake: a beat moves on a rising edge where t_valid && t_ready; t_valid must hold until then.
interface IAxiStream #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  t_valid;
    logic                  t_ready;
    logic                  t_last;
    logic [DATA_WIDTH-1:0] t_data;
    logic [ID_WIDTH-1:0]   t_id;

    modport master (output t_valid, t_last, t_data, t_id, input t_ready);
    modport slave  (input t_valid, t_last, t_data, t_id, output t_ready);
endinterface

// File: rtl/axi_arbiter_skid.sv
// Two-entry skid buffer that registers a valid/ready stream at full throughput.
// Only built when OUTPUT_REG_EN is defined; the default arbiter has no output register.
`ifdef OUTPUT_REG_EN
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Upstream ready is registered, so there is no combinational path from dn_ready.
    assign up_ready = !skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid   <= 1'b0;
            dn_data    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (up_valid && up_ready && dn_valid && !dn_ready) begin
                skid_valid <= 1'b1;
                skid_data  <= up_data;
            end
            if (!dn_valid || dn_ready) begin
                if (skid_valid) begin
                    dn_valid   <= 1'b1;
                    dn_data    <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    dn_valid <= up_valid && up_ready;
                    if (up_valid) begin
                        dn_data <= up_data;
                    end
                end
            end
        end
    end

endmodule
`endif

// File: rtl/axi_arbiter.sv
// Round-robin, packet-granular merge of four AXI-Stream inputs onto one output.
// Define OUTPUT_REG_EN to register the output (and idx_channel) through a skid buffer.
module axi_arbiter
    import axi_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    IAxiStream.slave  in_0,
    IAxiStream.slave  in_1,
    IAxiStream.slave  in_2,
    IAxiStream.slave  in_3,
    IAxiStream.master out,
    output ch_idx_t   idx_channel,
    output state_t    fsm_state
);

    state_t          state_q, state_d;
    ch_idx_t         grant_q, grant_d;
    ch_idx_t         rr_q, rr_d;
    ch_idx_t         cand;
    logic            found;
    logic [N_CH-1:0] req_valid;
    logic [N_CH-1:0] ch_ready;
    beat_t           req_beat [N_CH];
    beat_t           stage_beat;
    logic            stage_valid;
    logic            stage_ready;

    assign req_valid = {in_3.t_valid, in_2.t_valid, in_1.t_valid, in_0.t_valid};

    assign req_beat[0] = '{last: in_0.t_last, data: in_0.t_data, id: in_0.t_id};
    assign req_beat[1] = '{last: in_1.t_last, data: in_1.t_data, id: in_1.t_id};
    assign req_beat[2] = '{last: in_2.t_last, data: in_2.t_data, id: in_2.t_id};
    assign req_beat[3] = '{last: in_3.t_last, data: in_3.t_data, id: in_3.t_id};

    assign in_0.t_ready = ch_ready[0];
    assign in_1.t_ready = ch_ready[1];
    assign in_2.t_ready = ch_ready[2];
    assign in_3.t_ready = ch_ready[3];

    assign fsm_state = state_q;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        ch_ready    = '0;
        stage_valid = 1'b0;
        stage_beat  = req_beat[grant_q];
        found       = 1'b0;
        cand        = rr_q;
        case (state_q)
            IDLE: begin
                // Search upward from the pointer with wrap; the grant takes effect next cycle.
                for (int k = 0; k < N_CH; k++) begin
                    cand = rr_q + ch_idx_t'(k);
                    if (!found && req_valid[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stage_valid       = req_valid[grant_q];
                ch_ready[grant_q] = stage_ready;
                if (stage_valid && stage_ready && stage_beat.last) begin
                    state_d = IDLE;
                    rr_d    = grant_q + ch_idx_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef OUTPUT_REG_EN
    logic [BEAT_W+1:0] reg_out;

    // idx_channel travels with each beat so it stays aligned with the registered data.
    axis_skid_buffer #(
        .WIDTH(BEAT_W + 2)
    ) u_skid (
        .clk      (clk),
        .rst      (reset_n),
        .up_valid (stage_valid),
        .up_ready (stage_ready),
        .up_data  ({grant_q, stage_beat}),
        .dn_valid (out.t_valid),
        .dn_ready (out.t_ready),
        .dn_data  (reg_out)
    );

    assign {idx_channel, out.t_last, out.t_data, out.t_id} = reg_out;
`else
    assign out.t_valid  = stage_valid;
    assign out.t_last   = stage_beat.last;
    assign out.t_data   = stage_beat.data;
    assign out.t_id     = stage_beat.id;
    assign stage_ready  = out.t_ready;
    assign idx_channel  = grant_q;
`endif

endmodule

// File: tb/tb_axi_arbiter.sv
// Randomized bench for axi_arbiter: per-channel packet scoreboards plus a round-robin grant model.
module tb_axi_arbiter;
    import axi_arbiter_pkg::*;

    localparam int W = BEAT_W;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    IAxiStream ch0 ();
    IAxiStream ch1 ();
    IAxiStream ch2 ();
    IAxiStream ch3 ();
    IAxiStream out_s ();

    ch_idx_t    idx_channel;
    state_t     fsm_state;
    logic [3:0] v;
    beat_t      b [4];
    logic       out_ready;
    logic [3:0] in_rdy;

    assign ch0.t_valid = v[0];
    assign ch0.t_last  = b[0].last;
    assign ch0.t_data  = b[0].data;
    assign ch0.t_id    = b[0].id;
    assign ch1.t_valid = v[1];
    assign ch1.t_last  = b[1].last;
    assign ch1.t_data  = b[1].data;
    assign ch1.t_id    = b[1].id;
    assign ch2.t_valid = v[2];
    assign ch2.t_last  = b[2].last;
    assign ch2.t_data  = b[2].data;
    assign ch2.t_id    = b[2].id;
    assign ch3.t_valid = v[3];
    assign ch3.t_last  = b[3].last;
    assign ch3.t_data  = b[3].data;
    assign ch3.t_id    = b[3].id;
    assign out_s.t_ready = out_ready;
    assign in_rdy = {ch3.t_ready, ch2.t_ready, ch1.t_ready, ch0.t_ready};

    axi_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_0        (ch0),
        .in_1        (ch1),
        .in_2        (ch2),
        .in_3        (ch3),
        .out         (out_s),
        .idx_channel (idx_channel),
        .fsm_state   (fsm_state)
    );

    // scoreboard
    logic [W-1:0] src_q [4][$];
    logic [W-1:0] exp_q [4][$];
    int  total = 0;
    int  bad = 0;
    int  gap_pct = 0;
    int  rdy_pct = 100;
    int  m_rr = 0;
    int  m_grant = 0;
    bit  m_busy = 1'b0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < 4; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
            b[c] = '0;
        end
        v       = 4'b0;
        m_busy  = 1'b0;
        m_grant = 0;
        m_rr    = 0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b1;
        out_ready = 1'b0;
        clear_all();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
    endtask

    task automatic gen(logic [3:0] mask, int n);
        beat_t bt;
        int    len;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                for (int p = 0; p < n; p++) begin
                    len = $urandom_range(1, 16);
                    for (int i = 0; i < len; i++) begin
                        bt.last = (i == len - 1);
                        bt.data = $urandom;
                        bt.id   = ID_WIDTH'($urandom_range(0, 15));
                        src_q[c].push_back(bt);
                        exp_q[c].push_back(bt);
                    end
                end
            end
        end
    endtask

    // One cycle: observe and model at negedge, then drive new inputs just after posedge.
    task automatic step();
        logic [3:0] hs;
        logic       out_hs;
        beat_t      ob;
        int         g;
        bit         hit;
        @(negedge clk);
        hs     = v & in_rdy;
        out_hs = out_s.t_valid && out_ready;
        ob     = '{last: out_s.t_last, data: out_s.t_data, id: out_s.t_id};
        check_eq("state", fsm_state, m_busy);
        if (!m_busy) begin
            check_eq("idle_valid", out_s.t_valid, 0);
            check_eq("idle_ready", in_rdy, 0);
            check_eq("idle_idx", idx_channel, m_grant);
            if (v != 4'b0) begin
                hit = 1'b0;
                g   = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!hit && v[(m_rr + k) % 4]) begin
                        g   = (m_rr + k) % 4;
                        hit = 1'b1;
                    end
                end
                m_grant = g;
                m_busy  = 1'b1;
            end
        end else begin
            check_eq("busy_valid", out_s.t_valid, v[m_grant]);
            check_eq("busy_ready", in_rdy, out_ready ? (4'b1 << m_grant) : 4'b0);
            check_eq("busy_idx", idx_channel, m_grant);
            if (out_hs) begin
                if (exp_q[m_grant].size() == 0) begin
                    check_eq("beat_avail", exp_q[m_grant].size(), 1);
                end else begin
                    check_eq("beat", ob, exp_q[m_grant].pop_front());
                end
                if (ob.last) begin
                    m_rr   = (m_grant + 1) % 4;
                    m_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hs[c]) begin
                if (src_q[c].size() > 0) void'(src_q[c].pop_front());
                v[c] = 1'b0;
            end
            if (!v[c] && src_q[c].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                v[c] = 1'b1;
                b[c] = src_q[c][0];
            end
        end
        out_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (src_q[c].size() > 0 || exp_q[c].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic run_phase(string tag, int max_cycles);
        int n = 0;
        while ((pending() || m_busy) && n < max_cycles) begin
            step();
            n++;
        end
        check_eq({tag, "_in_time"}, n < max_cycles, 1);
        for (int c = 0; c < 4; c++) begin
            check_eq({tag, "_drain"}, exp_q[c].size(), 0);
        end
        if (n >= max_cycles) do_reset();
    endtask

    task automatic reset_mid_packet();
        int n = 0;
        gap_pct = 0;
        rdy_pct = 50;
        gen(4'hF, 10);
        while (!(m_busy && m_grant != 0) && n < 2000) begin
            step();
            n++;
        end
        check_eq("mid_busy_reached", n < 2000, 1);
        #2 reset_n = 1'b1;
        #1;
        check_eq("rst_out_valid", out_s.t_valid, 0);
        check_eq("rst_in_ready", in_rdy, 0);
        check_eq("rst_idx", idx_channel, 0);
        check_eq("rst_state", fsm_state, IDLE);
        clear_all();
        @(posedge clk);
        #1 reset_n = 1'b0;
    endtask

    initial begin
        beat_t bt;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        clear_all();
        v = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out_valid", out_s.t_valid, 0);
        check_eq("reset_in_ready", in_rdy, 0);
        check_eq("reset_idx", idx_channel, 0);
        check_eq("reset_state", fsm_state, IDLE);
        v = 4'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;

        // directed: single channel 2, three beats
        gap_pct = 0;
        rdy_pct = 100;
        bt = '{last: 1'b0, data: 32'hA, id: 4'd5};
        src_q[2].push_back(bt);
        exp_q[2].push_back(bt);
        bt = '{last: 1'b0, data: 32'hB, id: 4'd5};
        src_q[2].push_back(bt);
        exp_q[2].push_back(bt);
        bt = '{last: 1'b1, data: 32'hC, id: 4'd5};
        src_q[2].push_back(bt);
        exp_q[2].push_back(bt);
        run_phase("ch2_directed", 100);
        check_eq("ch2_last_idx", idx_channel, 2);

        // all channels, full-rate sink, fresh reset so channel 0 leads
        do_reset();
        gap_pct = 0;
        rdy_pct = 100;
        gen(4'hF, 20);
        run_phase("all_full", 5000);

        // all channels, 50% sink, 1000 packets
        gap_pct = 0;
        rdy_pct = 50;
        gen(4'hF, 250);
        run_phase("all_half", 45000);

        // valid gaps with random sink
        gap_pct = 40;
        rdy_pct = 50;
        gen(4'hF, 40);
        run_phase("gaps", 20000);

        // only channels 1 and 3 active
        gap_pct = 30;
        rdy_pct = 70;
        gen(4'b1010, 30);
        run_phase("ch13", 10000);

        // reset in the middle of a packet, then restart from channel 0
        reset_mid_packet();
        gap_pct = 0;
        rdy_pct = 80;
        gen(4'hF, 5);
        run_phase("after_reset", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Four-input AXI-Stream packet arbiter that merges in_0..in_3 onto one output stream.
- Grants are round-robin at packet granularity; channel 0 is served first after reset.
- A granted packet is forwarded beat-for-beat until its t_last handshake.
- Sits between multiple stream producers and one shared consumer; idx_channel reports the currently granted source.

Parameters:
- DATA_WIDTH, 32, width of t_data on all streams.
- ID_WIDTH, 4, width of t_id on all streams (passed through unchanged).
- N_CH, 4, number of input channels (fixed at 4; idx_channel width is clog2(N_CH)=2).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- reset_n  input  1  reset, asynchronous, active-high.
- in_0..in_3  IAxiStream slave modport  -  per channel: t_valid in 1, t_last in 1, t_data in DATA_WIDTH, t_id in ID_WIDTH, t_ready out 1.
- out  IAxiStream master modport  -  t_valid out 1, t_last out 1, t_data out DATA_WIDTH, t_id out ID_WIDTH, t_ready in 1.
- idx_channel  output  2  index of the granted input channel (AxiAddition sideband).

Behaviour:
- Reset (async assert, sync release). State IDLE, grant=0, rr pointer=0, idx_channel=0. out.t_valid=0 and all in_x.t_ready=0 while reset is high.
- States: IDLE and BUSY.
- IDLE: search requests (in_x.t_valid) starting at the rr pointer, ascending with wrap 3->0. The first requester found is registered as grant and the state moves to BUSY on the next edge. No request means stay in IDLE. All t_ready=0 and out.t_valid=0 in IDLE (one bubble cycle per packet).
- BUSY, combinational pass-through from in_grant:
  - out.t_valid/t_last/t_data/t_id = in_grant fields.
  - in_grant.t_ready = out.t_ready; every other in_x.t_ready=0.
  - No added latency in the default build.
- Beat transfer occurs when out.t_valid && out.t_ready. On a transfer with t_last=1: state goes to IDLE and the rr pointer becomes (grant+1) mod 4.
- Grant is never changed mid-packet, whatever other channels request. Deasserting t_valid mid-packet (a gap) keeps the grant.
- idx_channel = grant register. It is valid while BUSY and holds the last grant while IDLE.
- No beat is dropped, duplicated or reordered within a channel. t_id and t_data pass through bit-exact.
- All four channels requesting continuously gives service order 0,1,2,3,0,...
- Single-beat packets (t_valid and t_last in the same beat) are legal.
- Reset asserted mid-packet: the packet is aborted immediately and all outputs return to reset values. Upstream must restart its packets.

Optional Feature:
- Macro OUTPUT_REG_EN.
- Defined: a 2-entry skid buffer registers out.t_valid/t_last/t_data/t_id and idx_channel.
  - Adds 1 cycle forward latency.
  - Keeps full throughput.
  - in_grant.t_ready is driven by the buffer's ready, so no combinational path exists from out.t_ready.
  - The buffer is cleared by reset.
  - idx_channel is sampled with each beat so it stays aligned with the data.
- Undefined: the combinational pass-through described above.

Decomposition:
- Package axi_arbiter_pkg holds:
  - DATA_WIDTH, ID_WIDTH, N_CH constants;
  - ch_idx_t (logic [1:0]);
  - state enum {IDLE, BUSY};
  - beat struct {last, data, id}.
- IAxiStream (Master/Slave modports) and AxiAddition (idx_channel) are the existing interfaces.
- One natural sub-module: axis_skid_buffer, used only under OUTPUT_REG_EN.

Test Plan:
- All four channels each send 20 packets of random length 1..16, out.t_ready=1 -> all 80 packets arrive intact; idx_channel order 0,1,2,3 repeating; channel 0 first after reset.
- Only in_2 active, 3-beat packet data 0xA,0xB,0xC, t_id=5 -> out carries 0xA,0xB,0xC, t_id=5, t_last on 3rd beat, idx_channel=2.
- Random out.t_ready (50%), 1000 packets on all channels -> no lost or duplicated beats; data and t_id match per channel; round-robin order preserved.
- Random in_x.t_valid gaps plus random out.t_ready -> grant held across gaps; other channels' t_ready stay 0 until t_last handshake.
- Random inter-packet idle times -> idle channels are skipped, e.g. only 1 and 3 active gives order 1,3,1,3; no packet loss.
- reset_n high during a BUSY beat -> out.t_valid=0, all t_ready=0, idx_channel=0 immediately; next packet after release is granted from channel 0 onward.
